// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC / instruction-register stage feeding decode over valid/ready
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                        BUS_WIDTH    = 8,
  parameter int                        OPCODE_WIDTH = 8,
  parameter logic [BUS_WIDTH-1:0]      RESET_PC     = '0,
  parameter logic [OPCODE_WIDTH-1:0]   HALT_OPCODE  = '1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    stall,
  input  logic                    redirect_en,
  input  logic [BUS_WIDTH-1:0]    redirect_addr,
  input  logic                    resume,
  output logic [BUS_WIDTH-1:0]    addr_instr,
  output logic                    mem_en,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  output logic [OPCODE_WIDTH-1:0] ir_opcode,
  output logic [BUS_WIDTH-1:0]    ir_pc,
  output logic                    ir_valid,
  input  logic                    ir_ready,
  output logic                    halted
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [BUS_WIDTH-1:0] pc;
  logic                 fetch_go;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a redirect always lands in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (fetch_go && (opcode_in == HALT_OPCODE)) begin
          state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        if (resume || redirect_en) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // Output logic
  always_comb begin
    fetch_go = 1'b0;
    halted   = 1'b0;
    case (state)
      S_RUN: begin
        fetch_go = !stall && !redirect_en && (!ir_valid || ir_ready);
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        fetch_go = 1'b0;
        halted   = 1'b0;
      end
    endcase
  end

  assign mem_en     = fetch_go;
  assign addr_instr = pc;

  // PC and IR datapath: redirect > fetch > drain > hold
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc        <= RESET_PC;
      ir_opcode <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
    end else if (redirect_en) begin
      pc       <= redirect_addr;
      ir_valid <= 1'b0;
    end else if (fetch_go) begin
      ir_opcode <= opcode_in;
      ir_pc     <= pc;
      ir_valid  <= 1'b1;
      pc        <= pc + 1'b1;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic       clk;
  logic       nrst;
  logic       stall;
  logic       redirect_en;
  logic [7:0] redirect_addr;
  logic       resume;
  logic [7:0] addr_instr;
  logic       mem_en;
  logic [7:0] opcode_in;
  logic [7:0] ir_opcode;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic       halted;

  logic [7:0] mem [256];
  int         total;
  int         bad;

  fetch_unit #(
    .BUS_WIDTH    (8),
    .OPCODE_WIDTH (8),
    .RESET_PC     (8'h00),
    .HALT_OPCODE  (8'hFF)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .resume        (resume),
    .addr_instr    (addr_instr),
    .mem_en        (mem_en),
    .opcode_in     (opcode_in),
    .ir_opcode     (ir_opcode),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .halted        (halted)
  );

  // Asynchronous-read instruction memory model
  assign opcode_in = mem[addr_instr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'hFF] = 8'h7F;
    nrst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_addr = 8'h00;
    resume = 1'b0; ir_ready = 1'b1;

    // Reset state
    #3;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_addr", 32'(addr_instr), 32'h00);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ir_opcode", 32'(ir_opcode), 32'h00);
    step(); step();
    nrst = 1'b1;

    // Test 1: BOOT then streaming fetch
    check("boot_mem_en", 32'(mem_en), 32'd0);
    step();
    check("run_mem_en", 32'(mem_en), 32'd1);
    check("run_addr0", 32'(addr_instr), 32'h00);
    for (int k = 0; k <= 4; k++) begin
      step();
      check("stream_opcode", 32'(ir_opcode), 32'(k));
      check("stream_pc", 32'(ir_pc), 32'(k));
      check("stream_valid", 32'(ir_valid), 32'd1);
    end

    // Test 2: backpressure holds IR at ir_pc=4
    ir_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_mem_en", 32'(mem_en), 32'd0);
      check("bp_addr", 32'(addr_instr), 32'h05);
      check("bp_opcode", 32'(ir_opcode), 32'h04);
      check("bp_pc", 32'(ir_pc), 32'h04);
      check("bp_valid", 32'(ir_valid), 32'd1);
      step();
    end
    ir_ready = 1'b1;
    step();
    check("bp_next_opcode", 32'(ir_opcode), 32'h05);
    check("bp_next_pc", 32'(ir_pc), 32'h05);

    // Test 3: redirect flushes an unconsumed IR
    ir_ready = 1'b0;
    redirect_en = 1'b1; redirect_addr = 8'h40;
    #1;
    check("redir_mem_en", 32'(mem_en), 32'd0);
    step();
    redirect_en = 1'b0;
    check("redir_flush", 32'(ir_valid), 32'd0);
    check("redir_addr", 32'(addr_instr), 32'h40);
    ir_ready = 1'b1;
    step();
    check("redir_opcode", 32'(ir_opcode), 32'h40);
    check("redir_pc", 32'(ir_pc), 32'h40);
    check("redir_valid", 32'(ir_valid), 32'd1);

    // Stall blocks fetch but decode still drains
    stall = 1'b1;
    #1;
    check("stall_mem_en", 32'(mem_en), 32'd0);
    step();
    check("stall_drain", 32'(ir_valid), 32'd0);
    check("stall_addr", 32'(addr_instr), 32'h41);
    stall = 1'b0;

    // Test 4: PC wrap at 0xFF
    redirect_en = 1'b1; redirect_addr = 8'hFE;
    step();
    redirect_en = 1'b0;
    step();
    check("wrap_pc_fe", 32'(ir_pc), 32'hFE);
    step();
    check("wrap_pc_ff", 32'(ir_pc), 32'hFF);
    check("wrap_opcode", 32'(ir_opcode), 32'h7F);
    check("wrap_addr", 32'(addr_instr), 32'h00);

    // Test 5: halt opcode at addr 5, then resume
    mem[5] = 8'hFF;
    redirect_en = 1'b1; redirect_addr = 8'h05;
    step();
    redirect_en = 1'b0;
    check("halt_addr", 32'(addr_instr), 32'h05);
    step();
    check("halt_opcode", 32'(ir_opcode), 32'hFF);
    check("halt_pc", 32'(ir_pc), 32'h05);
    check("halt_valid", 32'(ir_valid), 32'd1);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_addr_inc", 32'(addr_instr), 32'h06);
    for (int k = 0; k < 10; k++) begin
      check("halted_mem_en", 32'(mem_en), 32'd0);
      check("halted_flag", 32'(halted), 32'd1);
      step();
    end
    check("halted_drained", 32'(ir_valid), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_flag", 32'(halted), 32'd0);
    check("resume_mem_en", 32'(mem_en), 32'd1);
    check("resume_addr", 32'(addr_instr), 32'h06);
    step();
    check("resume_opcode", 32'(ir_opcode), 32'h06);
    check("resume_pc", 32'(ir_pc), 32'h06);

    // Test 6: asynchronous reset mid-run with IR occupied
    ir_ready = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    check("arst_valid", 32'(ir_valid), 32'd0);
    check("arst_addr", 32'(addr_instr), 32'h00);
    check("arst_mem_en", 32'(mem_en), 32'd0);
    check("arst_opcode", 32'(ir_opcode), 32'h00);
    check("arst_halted", 32'(halted), 32'd0);
    step();
    nrst = 1'b1;
    ir_ready = 1'b1;
    check("arst_boot_mem_en", 32'(mem_en), 32'd0);
    step();
    check("arst_run_mem_en", 32'(mem_en), 32'd1);
    step();
    check("arst_first_opcode", 32'(ir_opcode), 32'h00);
    check("arst_first_valid", 32'(ir_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
